// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the fetch port and the load/store port.
// Data wins contention, but only for MAX_DATA_RUN grants in a row; then a waiting fetch goes through.
module mem_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int MAX_DATA_RUN = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_gnt,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_gnt,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_en,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-3:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic [DW-1:0]   m_rdata
);

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_INSTR = 2'd1,
        RESP_DATA  = 2'd2
    } resp_t;

    resp_t      resp_q, resp_d;
    logic [3:0] run_cnt_q, run_cnt_d;
    logic       fetch_turn;

    // Byte-offset bits are deliberately dropped; lane selection is done with d_be.
    logic       unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[1:0], d_addr[1:0]};

    assign fetch_turn = (run_cnt_q == 4'(MAX_DATA_RUN));

    always_comb begin
        i_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (i_req && d_req) begin
                i_gnt = fetch_turn;
                d_gnt = !fetch_turn;
            end else begin
                i_gnt = i_req;
                d_gnt = d_req;
            end
        end
    end

    assign m_en    = i_gnt | d_gnt;
    assign m_we    = d_gnt & d_we;
    assign m_be    = d_gnt ? d_be : '1;
    assign m_addr  = d_gnt ? d_addr[AW-1:2] : i_addr[AW-1:2];
    assign m_wdata = d_wdata;

    // Gating with rst kills a response whose grant happened just before reset.
    assign i_rvalid = !rst && (resp_q == RESP_INSTR);
    assign d_rvalid = !rst && (resp_q == RESP_DATA);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;

    always_comb begin
        resp_d = RESP_NONE;
        if (i_gnt) begin
            resp_d = RESP_INSTR;
        end else if (d_gnt && !d_we) begin
            resp_d = RESP_DATA;
        end
    end

    always_comb begin
        run_cnt_d = run_cnt_q;
        if (i_gnt || !i_req) begin
            run_cnt_d = 4'd0;
        end else if (d_gnt && (run_cnt_q != 4'hF)) begin
            run_cnt_d = run_cnt_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_q    <= RESP_NONE;
            run_cnt_q <= 4'd0;
        end else begin
            resp_q    <= resp_d;
            run_cnt_q <= run_cnt_d;
        end
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous RAM between the core's instruction-fetch port and its load/store data port. The core never has to stall on a structural conflict it cannot see. Each requester uses a req/gnt handshake with a one-cycle read response. Data accesses have priority, and a bounded-run counter guarantees fetch progress. The block sits between the core's memory ports and the unified RAM.

## Interface
Parameters:
- AW, 32, address width (byte address)
- DW, 32, data width
- MAX_DATA_RUN, 4, consecutive contended data grants before fetch is forced through (legal range 1..15)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- i_req  in  1  fetch request
- i_addr  in  AW  fetch byte address
- i_gnt  out  1  fetch request accepted this cycle
- i_rvalid  out  1  i_rdata valid this cycle
- i_rdata  out  DW  fetched word
- d_req  in  1  data request
- d_we  in  1  1 = write, 0 = read
- d_be  in  DW/8  write byte enables
- d_addr  in  AW  data byte address
- d_wdata  in  DW  write data
- d_gnt  out  1  data request accepted this cycle
- d_rvalid  out  1  d_rdata valid this cycle (reads only)
- d_rdata  out  DW  read word
- m_en  out  1  RAM access this cycle
- m_we  out  1  RAM write
- m_be  out  DW/8  RAM byte enables
- m_addr  out  AW-2  RAM word address (byte address >> 2)
- m_wdata  out  DW  RAM write data
- m_rdata  in  DW  RAM read data, valid one cycle after m_en && !m_we

## Operation
- Grant logic is combinational from req and state. At most one of i_gnt and d_gnt is asserted per cycle.
- A granted request drives m_* in the same cycle:
  - m_en = i_gnt | d_gnt
  - m_we = d_gnt & d_we
  - m_be = d_gnt ? d_be : all ones
  - m_addr = granted address [AW-1:2]
  - m_wdata = d_wdata
- Arbitration:
  - Only one req high: that requester is granted.
  - Both high: d wins unless run_cnt == MAX_DATA_RUN, in which case i wins.
- run_cnt is 4 bits and saturating. It updates once per cycle:
  - Reset to 0 on an i grant, or on any cycle with i_req low.
  - Incremented on a d grant while i_req is high.
- Response owner register resp ∈ {NONE, INSTR, DATA}. It is set to:
  - INSTR on an i grant
  - DATA on a d read grant
  - NONE otherwise (including d write grants)
- Next cycle: resp == INSTR asserts i_rvalid; resp == DATA asserts d_rvalid.
- i_rdata and d_rdata both carry m_rdata directly. They are meaningful only while their own rvalid is high.
- Requester rules:
  - Hold req, address and write fields stable until gnt.
  - req may drop or change in the cycle after gnt.
  - Back-to-back requests are accepted every cycle, so throughput is one access per cycle.
- Writes complete at grant; no write acknowledge is generated.
- Misaligned addresses: bits [1:0] are ignored, and lane selection is the requester's job via d_be.

## Timing
- Reset values while rst is high:
  - i_gnt = d_gnt = 0
  - m_en = m_we = 0
  - i_rvalid = d_rvalid = 0
  - resp = NONE, run_cnt = 0
  - Grants are forced low during rst even if req is high.
- Read latency: gnt in cycle N, rvalid with data in cycle N+1.
- Reset mid-operation: a grant in the cycle before rst asserts produces no rvalid in any later cycle. rst clears resp.
- Simultaneous requests every cycle with MAX_DATA_RUN = M give the grant pattern: M data, 1 fetch, repeating.
- A d grant and an i rvalid in the same cycle is legal, since pipelined responses overlap new grants.
- run_cnt saturation at 15 is unreachable with a legal MAX_DATA_RUN. It must not wrap.

## Test plan
- Reset: hold rst 3 cycles with i_req = d_req = 1 → no gnt, m_en = 0, no rvalid. First cycle after release → d_gnt = 1.
- Single fetch: RAM word 0x10 preloaded with 0x00500093; i_req, i_addr = 0x40 → i_gnt same cycle, m_addr = 0x10. Next cycle i_rvalid = 1, i_rdata = 0x00500093, d_rvalid = 0.
- Data write then read: d write 0xDEADBEEF to 0x80 with be = 4'b0011, word 0x20 preloaded 0 → granted, no d_rvalid. Then d read 0x80 → d_rvalid next cycle with d_rdata = 0x0000BEEF.
- Contention with MAX_DATA_RUN = 4: both req held 12 cycles → grants D,D,D,D,I,D,D,D,D,I,D,D. Each i grant is followed by i_rvalid.
- Back-to-back alternation: i_req every cycle, d_req every other cycle → no cycle with both gnts. Every grant is answered by the matching rvalid exactly one cycle later.
- Reset mid-read: d read granted in cycle N, rst asserted in N+1 → d_rvalid stays 0 in N+1 and N+2.
